// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and
// architectural constants used by the stall/flush logic.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSN = 32'h00000013;
  localparam logic [4:0]  REG_X0   = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: load-use bubbles, taken-branch squash,
// data-memory freeze with timeout, and saturating perf counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             perf_clr,
  output logic             pc_write,
  output logic             pc_sel_branch,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned      TMO_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             br_pend_q, br_pend_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             mem_err_q, mem_err_d;
  logic             stall_inc, flush_inc;
  logic             hazard_eval, branch;
  logic             load_use;

  assign load_use = ex_memread && (ex_rd != REG_X0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_d       = state_q;
    br_pend_d     = br_pend_q;
    tmo_d         = tmo_q;
    mem_err_d     = mem_err_q;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    hazard_eval   = 1'b0;
    branch        = 1'b0;
    pc_write      = 1'b1;
    pc_sel_branch = 1'b0;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_write  = 1'b1;

    case (state_q)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          {pc_write, if_id_write, id_ex_write, ex_mem_write} = '0;
          state_d   = MEM_WAIT;
          tmo_d     = TMO_W'(1);
          br_pend_d = ex_branch_taken;
          stall_inc = 1'b1;
        end else begin
          hazard_eval = 1'b1;
          branch      = ex_branch_taken;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          {pc_write, if_id_write, id_ex_write, ex_mem_write} = '0;
          stall_inc = 1'b1;
          br_pend_d = br_pend_q | ex_branch_taken;
          tmo_d     = tmo_q + TMO_W'(1);
          if (tmo_q == TMO_LAST) begin
            state_d   = ERROR;
            mem_err_d = 1'b1;
          end
        end else begin
          // Release cycle: a branch seen at any point during the freeze is honoured now.
          state_d     = RUN;
          tmo_d       = '0;
          br_pend_d   = 1'b0;
          hazard_eval = 1'b1;
          branch      = br_pend_q | ex_branch_taken;
        end
      end
      default: begin
        {pc_write, if_id_write, id_ex_write, ex_mem_write} = '0;
        mem_err_d = 1'b1;
      end
    endcase

    if (hazard_eval) begin
      if (branch) begin
        pc_sel_branch = 1'b1;
        if_id_flush   = 1'b1;
        id_ex_flush   = 1'b1;
        flush_inc     = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
        stall_inc   = 1'b1;
      end
    end

    if (!reset) begin
      {pc_write, pc_sel_branch, if_id_write, id_ex_write, ex_mem_write} = '0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      br_pend_q <= 1'b0;
      tmo_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      br_pend_q <= br_pend_d;
      tmo_q     <= tmo_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (perf_clr),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (perf_clr),
    .inc   (flush_inc),
    .cnt   (flush_cnt)
  );

endmodule
